dpi_pkt_sequencer: RTL and testbench
====================================

Name: dpi_pkt_sequencer

Overview:
- Front-end controller that sequences a bank of NUM_REGEX per-stream regex engine wrappers. Each wrapper keeps per-stream DFA state, uses the load_state/eop framing, and registers its inputs and outputs.
- For each packet: looks up the per-stream enable mask, issues the state-restore pulse, waits out the engine pipeline, streams bytes, drains the pipeline, then pulses eop. Captures the per-regex fired vector as a result record.
- Sits between the packet ingress FIFO and the regex bank.

Parameters:
- NUM_REGEX, 8, number of engines driven in lockstep (width of enable/fired/result).
- SID_W, 6, stream-id width (table depth 2**SID_W).
- LOAD_GAP, 3, cycles from the load_state pulse to the first char_in_vld; minimum 3.
- DRAIN_CYC, 4, cycles after the last char_in_vld before eop; minimum 4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- pkt_data  in  8  ingress byte.
- pkt_vld  in  1  ingress beat valid.
- pkt_sop  in  1  first beat of packet.
- pkt_eop  in  1  last beat of packet.
- pkt_sid  in  SID_W  stream id, valid with pkt_sop.
- pkt_sid_new  in  1  stream not previously seen, valid with pkt_sop.
- pkt_rdy  out  1  ingress accept; a beat transfers when pkt_vld & pkt_rdy.
- cfg_we  in  1  enable-table write strobe.
- cfg_addr  in  SID_W  enable-table index.
- cfg_wdata  in  NUM_REGEX  per-regex enable mask.
- load_state  out  1  one-cycle restore pulse to all engines.
- new_stream_id  out  1  to engines, meaningful with load_state.
- stream_id  out  SID_W  held constant from LOAD through EOP.
- enable  out  NUM_REGEX  latched mask, held LOAD through EOP.
- char_in  out  8  byte to engines.
- char_in_vld  out  1  byte valid.
- eop  out  1  one-cycle end-of-packet pulse to engines.
- fired  in  NUM_REGEX  engine fired flags.
- res_vld  out  1  result record valid.
- res_rdy  in  1  result consumer ready.
- res_sid  out  SID_W  stream id of the result.
- res_match  out  NUM_REGEX  fired & enable, sampled in the eop cycle.
- pkt_cnt  out  32  completed packets, wraps.
- drop_cnt  out  16  orphan beats dropped, saturates at 0xFFFF.

Behaviour:
- Reset: FSM=IDLE; all outputs 0; enable table cleared to 0; counters 0; result register empty.
- FSM states: IDLE, LOAD, GAP, STREAM, DRAIN, EOP.
- IDLE:
  - pkt_rdy=1.
  - Beat with pkt_sop: latch sid, new flag, enable=table[pkt_sid], and byte (and eop flag if also set) in a one-byte hold register. Go to LOAD.
  - Beat without pkt_sop: discard it, drop_cnt++.
- LOAD (1 cycle):
  - load_state=1, new_stream_id=latched flag, pkt_rdy=0.
  - Go to GAP.
  - Gap counter starts at LOAD_GAP-1.
- GAP:
  - pkt_rdy=0.
  - When the counter reaches 0, go to STREAM.
  - First char_in_vld occurs exactly LOAD_GAP cycles after load_state.
- STREAM:
  - The first cycle presents the held byte with char_in_vld=1.
  - Following cycles: pkt_rdy=1; each accepted beat drives char_in/char_in_vld in the next cycle (registered, 1-cycle latency). Bubbles are allowed.
  - pkt_sop inside a packet is ignored and the beat is treated as data.
  - On the beat flagged eop (held or accepted), pkt_rdy drops the following cycle. Go to DRAIN once that byte has been presented.
  - A sop+eop single-byte packet is legal.
- DRAIN:
  - No char_in_vld.
  - Wait DRAIN_CYC cycles after the last char_in_vld, then go to EOP.
- EOP:
  - If the result register is empty, or res_rdy=1 this cycle: eop=1 for one cycle; load res_sid and res_match=fired&enable; pkt_cnt++; go to IDLE.
  - Otherwise stall in EOP with eop=0 until the result register frees.
- Result handshake:
  - res_vld stays high until res_vld&res_rdy.
  - Fields are stable while res_vld.
  - A new load and a pop in the same cycle is allowed.
- cfg writes:
  - Take effect at any time.
  - The mask is latched at sop, so a write to the active sid affects only later packets.
  - A cfg write in the same cycle as a sop lookup on the same address returns the old value.
- No new load_state is issued until the prior eop has issued, so engine fired state never spans packets.
- Reset mid-packet: immediate return to IDLE with all outputs 0. Engine state for that stream is not saved.

Decomposition:
- Shared package holds:
  - The FSM state enum.
  - SID_W and NUM_REGEX defaults.
  - A result record typedef {sid, match}.
  - LOAD_GAP_MIN=3 and DRAIN_MIN=4 constants, checked by an elaboration assertion.
- One sub-module: dpi_enable_table, a 2**SID_W x NUM_REGEX register file with sync write and reset clear.

Test Plan:
- Reset, sid=5 marked new, 4-byte packet, enable=0xFF, fired=0x04 at eop → load_state at T; char_in_vld at T+3..T+6; eop at T+10; res_sid=5, res_match=0x04; pkt_cnt=1.
- Table[9]=0x0F, fired=0xFF, single-byte sop+eop packet → res_match=0x0F; exactly one char_in_vld.
- Two back-to-back packets (sids 1 and 2) with res_rdy=0 until 20 cycles after the first eop → second eop is withheld until the pop; both results are delivered in order, with no lost or duplicate eop.
- Three non-sop beats in IDLE, then a valid packet → drop_cnt=3; the packet is processed normally.
- Bubbles of pkt_vld=0 for 2 cycles mid-packet → char_in stream matches the input bytes in order; DRAIN still spans 4 cycles after the last byte.
- rst_n low for 1 cycle during STREAM → all outputs 0 next cycle; the next sop begins with a clean LOAD.

Source files
------------

// File: rtl/dpi_pkt_sequencer_pkg.sv
// Shared definitions for the DPI packet sequencer slice.
//   - default widths for the regex bank and the stream-id space
//   - minimum pipeline spacing constants enforced at elaboration
//   - sequencer FSM state encoding
//   - result record {sid, match} as seen by the result consumer
package dpi_pkt_sequencer_pkg;

  localparam int NUM_REGEX_DEF = 8;
  localparam int SID_W_DEF     = 6;

  // Engine wrappers register their inputs and outputs. Closer spacing
  // than this would let bytes or eop overtake the state restore.
  localparam int LOAD_GAP_MIN = 3;
  localparam int DRAIN_MIN    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_STREAM,
    ST_DRAIN,
    ST_EOP
  } seq_state_t;

  typedef struct packed {
    logic [SID_W_DEF-1:0]     sid;
    logic [NUM_REGEX_DEF-1:0] match;
  } result_t;

endpackage

// File: rtl/dpi_pkt_sequencer_if.sv
// Packet ingress bus between the ingress FIFO (master) and the sequencer
// (slave). A beat transfers when pkt_vld & pkt_rdy. pkt_sid and
// pkt_sid_new are only meaningful on the beat carrying pkt_sop.
//   pkt_data    8      ingress byte
//   pkt_vld     1      beat valid
//   pkt_sop     1      first beat of packet
//   pkt_eop     1      last beat of packet
//   pkt_sid     SID_W  stream id
//   pkt_sid_new 1      stream not previously seen
//   pkt_rdy     1      sequencer accepts the beat
interface dpi_pkt_sequencer_if
  import dpi_pkt_sequencer_pkg::*;
#(
  parameter int SID_W = SID_W_DEF
);
  logic [7:0]       pkt_data;
  logic             pkt_vld;
  logic             pkt_sop;
  logic             pkt_eop;
  logic [SID_W-1:0] pkt_sid;
  logic             pkt_sid_new;
  logic             pkt_rdy;

  modport master (
    output pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_sid, pkt_sid_new,
    input  pkt_rdy
  );

  modport slave (
    input  pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_sid, pkt_sid_new,
    output pkt_rdy
  );
endinterface

// File: rtl/dpi_enable_table.sv
// Per-stream regex enable masks: 2**ADDR_W entries of DATA_W bits.
// Synchronous write, combinational read, cleared by reset. A read of the
// address being written in the same cycle returns the old contents.
//   clk, rst_n  clock, synchronous active-low reset
//   i_we        write strobe
//   i_waddr     write index
//   i_wdata     write mask
//   i_raddr     read index
//   o_rdata     mask stored at i_raddr
module dpi_enable_table #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // NOTE: the table is a flop array, not a RAM macro, so it can be reset;
  // every stream must start with all regexes disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dpi_pkt_sequencer.sv
// Front-end sequencer for a bank of NUM_REGEX per-stream regex engines.
// Per packet: latch stream id and enable mask at sop, pulse load_state,
// wait LOAD_GAP cycles, stream bytes (1-cycle registered), wait DRAIN_CYC
// cycles after the last byte, pulse eop and capture fired & enable.
//   clk, rst_n          clock, synchronous active-low reset
//   pkt_if              ingress beats (slave side)
//   i_cfg_*             enable-table write port
//   o_load_state        restore pulse to engines, o_new_stream_id with it
//   o_stream_id         stream id held LOAD..EOP
//   o_enable            latched mask held LOAD..EOP
//   o_char_in(_vld)     byte stream to engines
//   o_eop               end-of-packet pulse to engines
//   i_fired             engine fired flags, sampled in the eop cycle
//   o_res_* / i_res_rdy result record with valid/ready handshake
//   o_pkt_cnt           completed packets (wraps)
//   o_drop_cnt          orphan beats dropped in IDLE (saturates)
module dpi_pkt_sequencer
  import dpi_pkt_sequencer_pkg::*;
#(
  parameter int NUM_REGEX = NUM_REGEX_DEF,
  parameter int SID_W     = SID_W_DEF,
  parameter int LOAD_GAP  = 3,
  parameter int DRAIN_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dpi_pkt_sequencer_if.slave   pkt_if,
  input  logic                 i_cfg_we,
  input  logic [SID_W-1:0]     i_cfg_addr,
  input  logic [NUM_REGEX-1:0] i_cfg_wdata,
  output logic                 o_load_state,
  output logic                 o_new_stream_id,
  output logic [SID_W-1:0]     o_stream_id,
  output logic [NUM_REGEX-1:0] o_enable,
  output logic [7:0]           o_char_in,
  output logic                 o_char_in_vld,
  output logic                 o_eop,
  input  logic [NUM_REGEX-1:0] i_fired,
  output logic                 o_res_vld,
  input  logic                 i_res_rdy,
  output logic [SID_W-1:0]     o_res_sid,
  output logic [NUM_REGEX-1:0] o_res_match,
  output logic [31:0]          o_pkt_cnt,
  output logic [15:0]          o_drop_cnt
);

  localparam int CNT_W = 8;

  if (LOAD_GAP < LOAD_GAP_MIN) begin : g_gap_chk
    $error("LOAD_GAP must be at least LOAD_GAP_MIN");
  end
  if (DRAIN_CYC < DRAIN_MIN) begin : g_drain_chk
    $error("DRAIN_CYC must be at least DRAIN_MIN");
  end
  if (LOAD_GAP >= 2**CNT_W || DRAIN_CYC >= 2**CNT_W) begin : g_cnt_chk
    $error("LOAD_GAP/DRAIN_CYC exceed the spacing counter range");
  end

  seq_state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [SID_W-1:0]     r_sid;
  logic                 r_new;
  logic [NUM_REGEX-1:0] r_en;
  logic [7:0]           r_hold;
  logic [7:0]           r_char;
  logic                 r_char_vld;
  logic                 r_eop_seen;
  logic                 r_live;
  logic                 r_res_vld;
  logic [SID_W-1:0]     r_res_sid;
  logic [NUM_REGEX-1:0] r_res_match;
  logic [31:0]          r_pkt_cnt;
  logic [15:0]          r_drop_cnt;

  logic                 w_pkt_rdy;
  logic                 w_accept;
  logic                 w_fire;
  logic [NUM_REGEX-1:0] w_tbl_mask;

  dpi_enable_table #(
    .ADDR_W (SID_W),
    .DATA_W (NUM_REGEX)
  ) u_enable_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (i_cfg_we),
    .i_waddr (i_cfg_addr),
    .i_wdata (i_cfg_wdata),
    .i_raddr (pkt_if.pkt_sid),
    .o_rdata (w_tbl_mask)
  );

  // r_live holds pkt_rdy low for the reset cycle itself so every output
  // reads 0 while rst_n is asserted. In STREAM, ready closes as soon as
  // the eop beat (held or accepted) is in.
  assign w_pkt_rdy = ((r_state == ST_IDLE) && r_live) ||
                     ((r_state == ST_STREAM) && !r_eop_seen);
  assign w_accept  = pkt_if.pkt_vld && w_pkt_rdy;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: defaults first, so no path through the case leaves a signal
  // unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    unique case (r_state)
      ST_IDLE:   if (w_accept && pkt_if.pkt_sop) w_state_nxt = ST_LOAD;
      ST_LOAD:   w_state_nxt = ST_GAP;
      ST_GAP:    if (r_cnt == '0) w_state_nxt = ST_STREAM;
      // The last byte is on char_in this cycle once eop has been seen.
      ST_STREAM: if (r_eop_seen && r_char_vld) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (r_cnt == '0) w_state_nxt = ST_EOP;
      ST_EOP: begin
        // A pop in the same cycle frees the result register for reuse.
        w_fire = !r_res_vld || i_res_rdy;
        if (w_fire) w_state_nxt = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_sid       <= '0;
      r_new       <= 1'b0;
      r_en        <= '0;
      r_hold      <= '0;
      r_char      <= '0;
      r_char_vld  <= 1'b0;
      r_eop_seen  <= 1'b0;
      r_live      <= 1'b0;
      r_res_vld   <= 1'b0;
      r_res_sid   <= '0;
      r_res_match <= '0;
      r_pkt_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_live     <= 1'b1;
      r_char_vld <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (pkt_if.pkt_sop) begin
              r_sid      <= pkt_if.pkt_sid;
              r_new      <= pkt_if.pkt_sid_new;
              r_en       <= w_tbl_mask;
              r_hold     <= pkt_if.pkt_data;
              r_eop_seen <= pkt_if.pkt_eop;
              // Counts down through LOAD and GAP; STREAM follows the
              // GAP cycle where it reads 0, i.e. LOAD_GAP after LOAD.
              r_cnt      <= CNT_W'(LOAD_GAP - 1);
            end else if (r_drop_cnt != 16'hFFFF) begin
              r_drop_cnt <= r_drop_cnt + 16'd1;
            end
          end
        end
        ST_LOAD: r_cnt <= r_cnt - CNT_W'(1);
        ST_GAP: begin
          if (r_cnt == '0) begin
            r_char     <= r_hold;
            r_char_vld <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_STREAM: begin
          // Any sop inside the packet is plain data here.
          if (w_accept) begin
            r_char     <= pkt_if.pkt_data;
            r_char_vld <= 1'b1;
            if (pkt_if.pkt_eop) r_eop_seen <= 1'b1;
          end
          // DRAIN lasts DRAIN_CYC-1 cycles so eop lands DRAIN_CYC after
          // the last byte.
          if (w_state_nxt == ST_DRAIN) r_cnt <= CNT_W'(DRAIN_CYC - 2);
        end
        ST_DRAIN: r_cnt <= r_cnt - CNT_W'(1);
        ST_EOP:   if (w_fire) r_pkt_cnt <= r_pkt_cnt + 32'd1;
        default: ;
      endcase

      if (w_fire) begin
        r_res_vld   <= 1'b1;
        r_res_sid   <= r_sid;
        r_res_match <= i_fired & r_en;
      end else if (i_res_rdy) begin
        r_res_vld <= 1'b0;
      end
    end
  end

  assign pkt_if.pkt_rdy  = w_pkt_rdy;
  assign o_load_state    = (r_state == ST_LOAD);
  assign o_new_stream_id = (r_state == ST_LOAD) && r_new;
  assign o_stream_id     = r_sid;
  assign o_enable        = r_en;
  assign o_char_in       = r_char;
  assign o_char_in_vld   = r_char_vld;
  assign o_eop           = w_fire;
  assign o_res_vld       = r_res_vld;
  assign o_res_sid       = r_res_sid;
  assign o_res_match     = r_res_match;
  assign o_pkt_cnt       = r_pkt_cnt;
  assign o_drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_dpi_pkt_sequencer.sv
// Scoreboard bench for dpi_pkt_sequencer. Stimulus pushes expected bytes
// and hand-computed result records into queues; a negedge monitor pops and
// compares whenever the DUT presents a byte or completes a result handshake,
// and time-stamps load_state / char_in_vld / eop for latency checks.
module tb_dpi_pkt_sequencer;
  import dpi_pkt_sequencer_pkg::*;

  localparam int SID_W = SID_W_DEF;
  localparam int NR    = NUM_REGEX_DEF;

  typedef logic [7:0] byte_q_t[$];

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [SID_W-1:0] cfg_addr = '0;
  logic [NR-1:0]    cfg_wdata = '0;
  logic             load_state, new_stream_id, char_in_vld, eop, res_vld;
  logic [SID_W-1:0] stream_id, res_sid;
  logic [NR-1:0]    enable, res_match;
  logic [7:0]       char_in;
  logic [NR-1:0]    fired = '0;
  logic             res_rdy = 1'b1;
  logic [31:0]      pkt_cnt;
  logic [15:0]      drop_cnt;

  dpi_pkt_sequencer_if #(.SID_W(SID_W)) pkt_if ();

  dpi_pkt_sequencer #(
    .NUM_REGEX (NR),
    .SID_W     (SID_W),
    .LOAD_GAP  (3),
    .DRAIN_CYC (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pkt_if          (pkt_if),
    .i_cfg_we        (cfg_we),
    .i_cfg_addr      (cfg_addr),
    .i_cfg_wdata     (cfg_wdata),
    .o_load_state    (load_state),
    .o_new_stream_id (new_stream_id),
    .o_stream_id     (stream_id),
    .o_enable        (enable),
    .o_char_in       (char_in),
    .o_char_in_vld   (char_in_vld),
    .o_eop           (eop),
    .i_fired         (fired),
    .o_res_vld       (res_vld),
    .i_res_rdy       (res_rdy),
    .o_res_sid       (res_sid),
    .o_res_match     (res_match),
    .o_pkt_cnt       (pkt_cnt),
    .o_drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_bytes[$];
  result_t    exp_res[$];

  int load_cyc, first_vld_cyc, last_vld_cyc, eop_cyc;
  int eop_cnt = 0;
  int vld_in_pkt = 0;
  logic             new_at_load;
  logic [SID_W-1:0] sid_at_load;
  logic [NR-1:0]    en_at_load;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic result_t mk_res(input logic [SID_W-1:0] s, input logic [NR-1:0] m);
    result_t r;
    r.sid   = s;
    r.match = m;
    return r;
  endfunction

  // Monitor: decoupled from stimulus, runs mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_state) begin
        load_cyc    = cyc;
        vld_in_pkt  = 0;
        new_at_load = new_stream_id;
        sid_at_load = stream_id;
        en_at_load  = enable;
      end
      if (char_in_vld) begin
        if (vld_in_pkt == 0) first_vld_cyc = cyc;
        last_vld_cyc = cyc;
        vld_in_pkt++;
        if (exp_bytes.size() == 0) check("char_unexpected", 32'd1, 32'd0);
        else check("char_in", {24'd0, char_in}, {24'd0, exp_bytes.pop_front()});
      end
      if (eop) begin
        eop_cyc = cyc;
        eop_cnt++;
      end
      if (res_vld && res_rdy) begin
        if (exp_res.size() == 0) begin
          check("res_unexpected", 32'd1, 32'd0);
        end else begin
          result_t e;
          e = exp_res.pop_front();
          check("res_sid", {26'd0, res_sid}, {26'd0, e.sid});
          check("res_match", {24'd0, res_match}, {24'd0, e.match});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cfg_write(input logic [SID_W-1:0] a, input logic [NR-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic sop, input logic eop_f,
                           input logic [SID_W-1:0] sid, input logic nw);
    bit took = 0;
    pkt_if.pkt_data = d; pkt_if.pkt_sop = sop; pkt_if.pkt_eop = eop_f;
    pkt_if.pkt_sid = sid; pkt_if.pkt_sid_new = nw; pkt_if.pkt_vld = 1'b1;
    for (int n = 0; n < 200 && !took; n++) begin
      @(negedge clk); took = pkt_if.pkt_rdy;
      @(posedge clk); #1;
    end
    if (!took) check("beat_accept_timeout", 32'd0, 32'd1);
    pkt_if.pkt_vld = 1'b0;
  endtask

  // Bytes are pushed to the scoreboard as they are issued. bub_at inserts
  // bub_len idle cycles before that beat; sop_at marks a stray mid-packet sop.
  task automatic send_pkt(input logic [SID_W-1:0] sid, input logic nw, input byte_q_t b,
                          input bit with_eop, input int bub_at, input int bub_len,
                          input int sop_at);
    for (int i = 0; i < b.size(); i++) begin
      exp_bytes.push_back(b[i]);
      if (i == bub_at) idle(bub_len);
      send_beat(b[i], (i == 0) || (i == sop_at), with_eop && (i == b.size() - 1), sid, nw);
    end
  endtask

  task automatic wait_res(input string name);
    int n = 0;
    while (exp_res.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    check({name, "_res_pending"}, exp_res.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_bytes(input string name);
    int n = 0;
    while (exp_bytes.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    check({name, "_bytes_pending"}, exp_bytes.size(), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_pkt_rdy"},    {31'd0, pkt_if.pkt_rdy}, 32'd0);
    check({name, "_load_state"}, {31'd0, load_state}, 32'd0);
    check({name, "_char_vld"},   {31'd0, char_in_vld}, 32'd0);
    check({name, "_char_in"},    {24'd0, char_in}, 32'd0);
    check({name, "_eop"},        {31'd0, eop}, 32'd0);
    check({name, "_stream_id"},  {26'd0, stream_id}, 32'd0);
    check({name, "_enable"},     {24'd0, enable}, 32'd0);
    check({name, "_res_vld"},    {31'd0, res_vld}, 32'd0);
    check({name, "_pkt_cnt"},    pkt_cnt, 32'd0);
    check({name, "_drop_cnt"},   {16'd0, drop_cnt}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t pk;
    int base, e1, rel, n;

    pkt_if.pkt_data = '0; pkt_if.pkt_vld = 1'b0; pkt_if.pkt_sop = 1'b0;
    pkt_if.pkt_eop = 1'b0; pkt_if.pkt_sid = '0; pkt_if.pkt_sid_new = 1'b0;

    // Reset state, observed while rst_n is still low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // 1: sid 5 new, 4 bytes, mask FF, fired 04.
    cfg_write(6'd5, 8'hFF);
    fired = 8'h04;
    exp_res.push_back(mk_res(6'd5, 8'h04));
    pk = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_pkt(6'd5, 1'b1, pk, 1'b1, -1, 0, -1);
    wait_res("t1");
    check("t1_load_to_first", first_vld_cyc - load_cyc, 32'd3);
    check("t1_first_to_last", last_vld_cyc - first_vld_cyc, 32'd3);
    check("t1_load_to_eop", eop_cyc - load_cyc, 32'd10);
    check("t1_new_flag", {31'd0, new_at_load}, 32'd1);
    check("t1_sid_at_load", {26'd0, sid_at_load}, 32'd5);
    check("t1_en_at_load", {24'd0, en_at_load}, 32'hFF);
    check("t1_pkt_cnt", pkt_cnt, 32'd1);
    idle(2);

    // 2: single-byte sop+eop packet, mask 0F, fired FF.
    cfg_write(6'd9, 8'h0F);
    fired = 8'hFF;
    exp_res.push_back(mk_res(6'd9, 8'h0F));
    pk = '{8'h5A};
    send_pkt(6'd9, 1'b0, pk, 1'b1, -1, 0, -1);
    wait_res("t2");
    check("t2_vld_count", vld_in_pkt, 32'd1);
    check("t2_load_to_first", first_vld_cyc - load_cyc, 32'd3);
    check("t2_drain", eop_cyc - last_vld_cyc, 32'd4);
    check("t2_new_flag", {31'd0, new_at_load}, 32'd0);
    check("t2_pkt_cnt", pkt_cnt, 32'd2);
    idle(2);

    // 3: back-to-back sids 1 and 2 with the result consumer stalled.
    // The sid-1 mask is rewritten after its sop; its result keeps 0x11.
    res_rdy = 1'b0;
    cfg_write(6'd1, 8'h11);
    cfg_write(6'd2, 8'h22);
    fired = 8'h33;
    base = eop_cnt;
    exp_res.push_back(mk_res(6'd1, 8'h11));
    exp_res.push_back(mk_res(6'd2, 8'h22));
    pk = '{8'h11, 8'h12};
    send_pkt(6'd1, 1'b1, pk, 1'b1, -1, 0, -1);
    cfg_write(6'd1, 8'h00);
    pk = '{8'h21, 8'h22};
    send_pkt(6'd2, 1'b1, pk, 1'b1, -1, 0, -1);
    n = 0;
    while (eop_cnt < base + 1 && n < 300) begin @(posedge clk); #1; n++; end
    check("t3_first_eop", eop_cnt, base + 1);
    e1 = eop_cyc;
    while (cyc < e1 + 20) begin @(posedge clk); #1; end
    @(negedge clk);
    check("t3_eop_withheld", eop_cnt, base + 1);
    check("t3_res_vld_held", {31'd0, res_vld}, 32'd1);
    check("t3_res_sid_held", {26'd0, res_sid}, 32'd1);
    check("t3_res_match_held", {24'd0, res_match}, 32'h11);
    @(posedge clk); #1;
    res_rdy = 1'b1;
    rel = cyc;
    wait_res("t3");
    check("t3_eop_total", eop_cnt, base + 2);
    check("t3_eop_at_pop", eop_cyc, rel);
    check("t3_pkt_cnt", pkt_cnt, 32'd4);
    idle(2);

    // 4: three orphan beats in IDLE, then a normal packet.
    repeat (3) send_beat(8'hEE, 1'b0, 1'b0, 6'd3, 1'b0);
    @(negedge clk);
    check("t4_drop_cnt", {16'd0, drop_cnt}, 32'd3);
    @(posedge clk); #1;
    cfg_write(6'd3, 8'hA5);
    fired = 8'h3C;
    exp_res.push_back(mk_res(6'd3, 8'h24));
    pk = '{8'h31, 8'h32};
    send_pkt(6'd3, 1'b0, pk, 1'b1, -1, 0, -1);
    wait_res("t4");
    check("t4_vld_count", vld_in_pkt, 32'd2);
    check("t4_pkt_cnt", pkt_cnt, 32'd5);
    check("t4_drop_after", {16'd0, drop_cnt}, 32'd3);
    idle(2);

    // 5: 2-cycle bubble before byte 3, stray sop on byte 4.
    cfg_write(6'd4, 8'hF0);
    exp_res.push_back(mk_res(6'd4, 8'h30));
    pk = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    send_pkt(6'd4, 1'b0, pk, 1'b1, 2, 2, 3);
    wait_res("t5");
    check("t5_vld_count", vld_in_pkt, 32'd5);
    check("t5_first_to_last", last_vld_cyc - first_vld_cyc, 32'd6);
    check("t5_drain", eop_cyc - last_vld_cyc, 32'd4);
    check("t5_pkt_cnt", pkt_cnt, 32'd6);
    idle(2);

    // 6: one-cycle reset in STREAM, then a clean packet.
    cfg_write(6'd6, 8'h5A);
    fired = 8'hFF;
    pk = '{8'h61, 8'h62, 8'h63};
    send_pkt(6'd6, 1'b0, pk, 1'b0, -1, 0, -1);
    wait_bytes("t6");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("t6_midreset");
    @(posedge clk); #1;
    cfg_write(6'd7, 8'hC3);
    exp_res.push_back(mk_res(6'd7, 8'hC3));
    pk = '{8'h77};
    send_pkt(6'd7, 1'b1, pk, 1'b1, -1, 0, -1);
    wait_res("t6");
    check("t6_load_to_first", first_vld_cyc - load_cyc, 32'd3);
    check("t6_vld_count", vld_in_pkt, 32'd1);
    check("t6_new_flag", {31'd0, new_at_load}, 32'd1);
    check("t6_sid_at_load", {26'd0, sid_at_load}, 32'd7);
    check("t6_pkt_cnt", pkt_cnt, 32'd1);

    idle(3);
    check("end_bytes_left", exp_bytes.size(), 32'd0);
    check("end_res_left", exp_res.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
